// File: rtl/sparse_pos_aligner_pkg.sv
// rtl/sparse_pos_aligner_pkg.sv - shared defaults and FSM encoding for the sparse position aligner
package sparse_pos_aligner_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int MAX_SIZE   = 19;
  localparam int IDX_W      = 5;
  localparam int POS_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ALIGN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/sparse_pos_aligner_if.sv
// rtl/sparse_pos_aligner_if.sv - position, word-pair and result buses of the aligner
interface sparse_pos_aligner_if #(
  parameter int WORD_WIDTH = sparse_pos_aligner_pkg::WORD_WIDTH,
  parameter int IDX_W      = sparse_pos_aligner_pkg::IDX_W,
  parameter int POS_W      = sparse_pos_aligner_pkg::POS_W
) ();
  import sparse_pos_aligner_pkg::*;

  logic [POS_W-1:0]      pos_in;
  logic                  pos_dummy;
  logic                  pos_valid;
  logic                  pos_ready;
  logic                  abort;
  logic                  sr_ready;
  logic [IDX_W-1:0]      sr_size;
  logic [IDX_W-1:0]      high_right_idx, high_left_idx, low_right_idx, low_left_idx;
  logic                  high_right_valid, high_left_valid, low_right_valid, low_left_valid;
  logic                  get_pair;
  logic                  pair_valid;
  logic [WORD_WIDTH-1:0] high_right_word, high_left_word, low_right_word, low_left_word;
  logic [WORD_WIDTH-1:0] out_high, out_low;
  logic                  out_dummy;
  logic                  out_valid;
  logic                  out_ready;

  // master is the aligner itself; slave is the surrounding shift_register/consumer side
  modport master (
    input  pos_in, pos_dummy, pos_valid, abort, sr_ready, sr_size, pair_valid,
           high_right_word, high_left_word, low_right_word, low_left_word, out_ready,
    output pos_ready, high_right_idx, high_left_idx, low_right_idx, low_left_idx,
           high_right_valid, high_left_valid, low_right_valid, low_left_valid,
           get_pair, out_high, out_low, out_dummy, out_valid
  );

  modport slave (
    output pos_in, pos_dummy, pos_valid, abort, sr_ready, sr_size, pair_valid,
           high_right_word, high_left_word, low_right_word, low_left_word, out_ready,
    input  pos_ready, high_right_idx, high_left_idx, low_right_idx, low_left_idx,
           high_right_valid, high_left_valid, low_right_valid, low_left_valid,
           get_pair, out_high, out_low, out_dummy, out_valid
  );

endinterface

// File: rtl/sparse_pos_aligner_pair_funnel_shifter.sv
// rtl/sparse_pos_aligner_pair_funnel_shifter.sv - combinational {left,right} >> s word extractor
module pair_funnel_shifter #(
  parameter int WORD_WIDTH = sparse_pos_aligner_pkg::WORD_WIDTH,
  parameter int SHIFT_W    = $clog2(WORD_WIDTH)
) (
  input  logic [WORD_WIDTH-1:0] left,
  input  logic [WORD_WIDTH-1:0] right,
  input  logic                  left_v,
  input  logic                  right_v,
  input  logic [SHIFT_W-1:0]    s,
  output logic [WORD_WIDTH-1:0] word
);
  import sparse_pos_aligner_pkg::*;

  logic [WORD_WIDTH-1:0]   left_m, right_m;
  logic [2*WORD_WIDTH-1:0] pair;

  // words beyond the live shift_register contents contribute zeros, whatever the bus carries
  always_comb begin
    left_m  = left_v  ? left  : '0;
    right_m = right_v ? right : '0;
    pair    = {left_m, right_m};
    word    = WORD_WIDTH'(pair >> s);
  end

endmodule

// File: rtl/sparse_pos_aligner.sv
// rtl/sparse_pos_aligner.sv - turns a sparse bit position into two word-aligned operands
module sparse_pos_aligner #(
  parameter int WORD_WIDTH = sparse_pos_aligner_pkg::WORD_WIDTH,
  parameter int MAX_SIZE   = sparse_pos_aligner_pkg::MAX_SIZE,
  parameter int IDX_W      = sparse_pos_aligner_pkg::IDX_W,
  parameter int POS_W      = sparse_pos_aligner_pkg::POS_W
) (
  input logic                clk,
  input logic                rst_n,
  sparse_pos_aligner_if.master bus
);
  import sparse_pos_aligner_pkg::*;

  // WORD_WIDTH is a power of two, so divide/modulo reduce to a shift and a bit slice
  localparam int SHIFT_W = $clog2(WORD_WIDTH);

  if ((2 ** POS_W) < (MAX_SIZE * WORD_WIDTH)) begin : g_pos_w_check
    $error("POS_W cannot address MAX_SIZE*WORD_WIDTH bits");
  end

  state_t                state;
  logic [SHIFT_W-1:0]    shift_r;
  logic                  dummy_r;
  logic [WORD_WIDTH-1:0] hr_w, hl_w, lr_w, ll_w;
  logic [WORD_WIDTH-1:0] high_aligned, low_aligned;
  logic [IDX_W:0]        w_ext, idx1, idx2, size_ext;
  logic                  accept;

  // one extra bit so w+1/w+2 past the index range compare as invalid instead of wrapping
  assign w_ext    = (IDX_W+1)'(bus.pos_in >> SHIFT_W);
  assign idx1     = w_ext + (IDX_W+1)'(1);
  assign idx2     = w_ext + (IDX_W+1)'(2);
  assign size_ext = {1'b0, bus.sr_size};

  assign bus.pos_ready = rst_n && (state == ST_IDLE) && bus.sr_ready;
  assign accept        = bus.pos_valid && bus.pos_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= ST_IDLE;
      shift_r              <= '0;
      dummy_r              <= 1'b0;
      hr_w                 <= '0;
      hl_w                 <= '0;
      lr_w                 <= '0;
      ll_w                 <= '0;
      bus.high_right_idx   <= '0;
      bus.high_left_idx    <= '0;
      bus.low_right_idx    <= '0;
      bus.low_left_idx     <= '0;
      bus.high_right_valid <= 1'b0;
      bus.high_left_valid  <= 1'b0;
      bus.low_right_valid  <= 1'b0;
      bus.low_left_valid   <= 1'b0;
      bus.get_pair         <= 1'b0;
      bus.out_high         <= '0;
      bus.out_low          <= '0;
      bus.out_dummy        <= 1'b0;
      bus.out_valid        <= 1'b0;
    end else if (bus.abort) begin
      state         <= ST_IDLE;
      bus.get_pair  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            bus.low_right_idx    <= w_ext[IDX_W-1:0];
            bus.low_left_idx     <= idx1[IDX_W-1:0];
            bus.high_right_idx   <= idx1[IDX_W-1:0];
            bus.high_left_idx    <= idx2[IDX_W-1:0];
            bus.low_right_valid  <= w_ext < size_ext;
            bus.low_left_valid   <= idx1 < size_ext;
            bus.high_right_valid <= idx1 < size_ext;
            bus.high_left_valid  <= idx2 < size_ext;
            shift_r              <= bus.pos_in[SHIFT_W-1:0];
            dummy_r              <= bus.pos_dummy;
            bus.get_pair         <= 1'b1;
            state                <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.pair_valid) begin
            hr_w         <= bus.high_right_word;
            hl_w         <= bus.high_left_word;
            lr_w         <= bus.low_right_word;
            ll_w         <= bus.low_left_word;
            bus.get_pair <= 1'b0;
            state        <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          bus.out_high  <= high_aligned;
          bus.out_low   <= low_aligned;
          bus.out_dummy <= dummy_r;
          bus.out_valid <= 1'b1;
          state         <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pair_funnel_shifter #(.WORD_WIDTH(WORD_WIDTH), .SHIFT_W(SHIFT_W)) u_high (
    .left    (hl_w),
    .right   (hr_w),
    .left_v  (bus.high_left_valid),
    .right_v (bus.high_right_valid),
    .s       (shift_r),
    .word    (high_aligned)
  );

  pair_funnel_shifter #(.WORD_WIDTH(WORD_WIDTH), .SHIFT_W(SHIFT_W)) u_low (
    .left    (ll_w),
    .right   (lr_w),
    .left_v  (bus.low_left_valid),
    .right_v (bus.low_right_valid),
    .s       (shift_r),
    .word    (low_aligned)
  );

endmodule

// File: tb/tb_sparse_pos_aligner.sv
// tb/tb_sparse_pos_aligner.sv - scoreboard bench for sparse_pos_aligner
module tb_sparse_pos_aligner;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sparse_pos_aligner_if bus ();
  sparse_pos_aligner dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dum;
    int          acc;
    int          lat;
  } out_t;

  typedef struct {
    logic [4:0] lr;
    logic [3:0] fl;
  } req_t;

  out_t        out_q[$];
  req_t        req_q[$];
  logic [31:0] mem [0:18];
  int          n_chk = 0, n_fail = 0, cyc = 0, pair_delay = 0, rcnt = 0;
  bit          req_seen = 0, seen = 0;
  logic [31:0] held_hi, held_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [4:0] idx);
    return (idx < 5'd19) ? mem[idx] : 32'hDEADBEEF;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // shift_register model: answers get_pair after pair_delay cycles, checks the request once
  always @(posedge clk) begin
    #1;
    if (bus.get_pair) begin
      if (!req_seen) begin
        req_seen = 1;
        if (req_q.size() == 0) begin
          chk("unexpected_request", 32'd1, 32'd0);
        end else begin
          req_t r;
          logic [4:0] l1, l2;
          r  = req_q.pop_front();
          l1 = r.lr + 5'd1;
          l2 = r.lr + 5'd2;
          chk("request_idx", {12'd0, bus.high_left_idx, bus.high_right_idx, bus.low_left_idx, bus.low_right_idx},
              {12'd0, l2, l1, l1, r.lr});
          chk("request_flags", {28'd0, bus.high_left_valid, bus.high_right_valid, bus.low_left_valid, bus.low_right_valid},
              {28'd0, r.fl});
        end
      end
      bus.pair_valid = (rcnt >= pair_delay);
      rcnt++;
    end else begin
      req_seen       = 0;
      rcnt           = 0;
      bus.pair_valid = 1'b0;
    end
    bus.high_right_word = word_at(bus.high_right_idx);
    bus.high_left_word  = word_at(bus.high_left_idx);
    bus.low_right_word  = word_at(bus.low_right_idx);
    bus.low_left_word   = word_at(bus.low_left_idx);
  end

  // result monitor
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (out_q.size() == 0) begin
        if (!seen) chk("unexpected_output", 32'd1, 32'd0);
        seen = 1;
      end else begin
        if (!seen) begin
          seen = 1;
          if (out_q[0].lat >= 0) chk("latency", cyc - out_q[0].acc, out_q[0].lat);
        end
        if (bus.out_ready) begin
          out_t e;
          e = out_q.pop_front();
          chk("out_high", bus.out_high, e.hi);
          chk("out_low", bus.out_low, e.lo);
          chk("out_dummy", {31'd0, bus.out_dummy}, {31'd0, e.dum});
          seen = 0;
        end
      end
    end else begin
      seen = 0;
    end
  end

  // entered and left at posedge+1
  task automatic send(input logic [9:0] p, input logic d, input logic [4:0] lr, input logic [3:0] fl,
                      input bit want_out, input logic [31:0] hi, input logic [31:0] lo, input int lat);
    int n = 0;
    while (!bus.pos_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("pos_ready_timeout", 32'd0, 32'd1);
    bus.pos_in    = p;
    bus.pos_dummy = d;
    bus.pos_valid = 1'b1;
    req_q.push_back('{lr: lr, fl: fl});
    if (want_out) out_q.push_back('{hi: hi, lo: lo, dum: d, acc: cyc, lat: lat});
    @(posedge clk); #1;
    bus.pos_valid = 1'b0;
    bus.pos_dummy = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((out_q.size() != 0 || bus.out_valid) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mem[0] = 32'hF0F0F0F0; mem[1] = 32'h0F0F0F0F; mem[2] = 32'hAAAAAAAA;
    mem[3] = 32'h55555555; mem[4] = 32'h12345678; mem[5] = 32'h87654321;
    for (int i = 6; i < 18; i++) mem[i] = 32'h01010101 * i;
    mem[18] = 32'hCAFEBABE;

    rst_n = 1'b0;
    bus.pos_in = '0; bus.pos_dummy = 1'b0; bus.pos_valid = 1'b0; bus.abort = 1'b0;
    bus.sr_ready = 1'b1; bus.sr_size = 5'd19; bus.out_ready = 1'b1; bus.pair_valid = 1'b0;
    bus.high_right_word = '0; bus.high_left_word = '0; bus.low_right_word = '0; bus.low_left_word = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_pos_ready", {31'd0, bus.pos_ready}, 32'd0);
    chk("reset_get_pair", {31'd0, bus.get_pair}, 32'd0);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_out_dummy", {31'd0, bus.out_dummy}, 32'd0);
    chk("reset_out_high", bus.out_high, 32'd0);
    chk("reset_out_low", bus.out_low, 32'd0);
    chk("reset_flags", {28'd0, bus.high_left_valid, bus.high_right_valid, bus.low_left_valid, bus.low_right_valid}, 32'd0);
    chk("reset_idx", {12'd0, bus.high_left_idx, bus.high_right_idx, bus.low_left_idx, bus.low_right_idx}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_pos_ready", {31'd0, bus.pos_ready}, 32'd1);
    bus.sr_ready = 1'b0;
    #1 chk("sr_not_ready_blocks", {31'd0, bus.pos_ready}, 32'd0);
    bus.sr_ready = 1'b1;
    @(posedge clk); #1;

    send(10'd72, 1'b0, 5'd2, 4'hF, 1, 32'h78555555, 32'h55AAAAAA, 3);
    drain();
    send(10'd72, 1'b1, 5'd2, 4'hF, 1, 32'h78555555, 32'h55AAAAAA, 3);
    drain();
    send(10'd128, 1'b0, 5'd4, 4'hF, 1, 32'h87654321, 32'h12345678, 3);
    drain();
    pair_delay = 2;
    send(10'd128, 1'b0, 5'd4, 4'hF, 1, 32'h87654321, 32'h12345678, 5);
    drain();
    pair_delay = 0;
    send(10'd580, 1'b0, 5'd18, 4'b0001, 1, 32'h00000000, 32'h0CAFEBAB, 3);
    drain();
    bus.sr_size = 5'd10;
    send(10'd400, 1'b0, 5'd12, 4'b0000, 1, 32'h00000000, 32'h00000000, 3);
    drain();
    bus.sr_size = 5'd31;
    send(10'd964, 1'b0, 5'd30, 4'b0001, 1, 32'h00000000, 32'h0DEADBEE, 3);
    drain();
    bus.sr_size = 5'd19;

    // consumer stall
    bus.out_ready = 1'b0;
    send(10'd128, 1'b0, 5'd4, 4'hF, 1, 32'h87654321, 32'h12345678, 3);
    for (int n = 0; n < 50 && !bus.out_valid; n++) @(negedge clk);
    chk("stall_out_valid_seen", {31'd0, bus.out_valid}, 32'd1);
    held_hi = bus.out_high;
    held_lo = bus.out_low;
    repeat (5) begin
      @(negedge clk);
      chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_out_high", bus.out_high, held_hi);
      chk("stall_out_low", bus.out_low, held_lo);
      chk("stall_pos_ready", {31'd0, bus.pos_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("release_pos_ready", {31'd0, bus.pos_ready}, 32'd1);
    @(posedge clk); #1;

    // abort together with a position offer in IDLE
    bus.pos_in = 10'd72; bus.pos_valid = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.pos_valid = 1'b0; bus.abort = 1'b0;
    chk("abort_idle_get_pair", {31'd0, bus.get_pair}, 32'd0);
    chk("abort_idle_pos_ready", {31'd0, bus.pos_ready}, 32'd1);

    // abort while waiting in REQ
    pair_delay = 100;
    send(10'd72, 1'b0, 5'd2, 4'hF, 0, 32'h0, 32'h0, -1);
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort_req_get_pair", {31'd0, bus.get_pair}, 32'd0);
    chk("abort_req_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_req_pos_ready", {31'd0, bus.pos_ready}, 32'd1);
    pair_delay = 0;
    repeat (5) @(posedge clk);
    #1;
    send(10'd72, 1'b0, 5'd2, 4'hF, 1, 32'h78555555, 32'h55AAAAAA, 3);
    drain();

    // reset pulse while in ALIGN
    send(10'd128, 1'b0, 5'd4, 4'hF, 0, 32'h0, 32'h0, -1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_align_get_pair", {31'd0, bus.get_pair}, 32'd0);
    chk("rst_align_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_align_pos_ready", {31'd0, bus.pos_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    send(10'd72, 1'b0, 5'd2, 4'hF, 1, 32'h78555555, 32'h55AAAAAA, 3);
    drain();

    repeat (3) @(posedge clk);
    chk("queues_drained", out_q.size() + req_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sparse_pos_aligner.md
Name: sparse_pos_aligner

Overview:
- Downstream consumer and request master of the word shift_register in the sparse polynomial multiplier.
- Accepts one sparse-coefficient bit position per transaction and converts it into word indices plus a bit offset.
- Fetches the two word pairs from shift_register, funnel-shifts each pair by the offset, and emits two aligned words: high and low.
- Dummy positions from the dummy-insertion scheme run through the identical sequence and timing; they are only flagged at the output.

Parameters:
- WORD_WIDTH, 32, word width in bits.
- MAX_SIZE, 19, shift_register capacity in words.
- IDX_W, 5, word index width.
- POS_W, 10, bit position width; must satisfy 2^POS_W >= MAX_SIZE*WORD_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pos_in  in  POS_W  sparse bit position.
- pos_dummy  in  1  position is a dummy insertion.
- pos_valid  in  1  position offered.
- pos_ready  out  1  aligner can accept a position.
- abort  in  1  synchronous flush to IDLE.
- sr_ready  in  1  shift_register ready.
- sr_size  in  IDX_W  shift_register current_size.
- high_right_idx, high_left_idx, low_right_idx, low_left_idx  out  IDX_W each  word requests.
- high_right_valid, high_left_valid, low_right_valid, low_left_valid  out  1 each  index-valid flags.
- get_pair  out  1  pair request.
- pair_valid  in  1  pair words valid.
- high_right_word, high_left_word, low_right_word, low_left_word  in  WORD_WIDTH each  fetched words.
- out_high, out_low  out  WORD_WIDTH each  aligned words.
- out_dummy  out  1  dummy flag, passed through.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset, asynchronous: state=IDLE. get_pair, out_valid, out_dummy, every *_valid flag = 0. All idx outputs, out_high and out_low = 0. pos_ready = 0 while rst_n is low.
- Index computation, registered when a position is accepted:
  - w = pos_in / WORD_WIDTH; s = pos_in % WORD_WIDTH.
  - low_right = w, low_left = w+1, high_right = w+1, high_left = w+2.
  - Each index sum is computed at IDX_W+1 bits.
  - A flag is set iff its index < sr_size, so an index that overflows IDX_W is invalid.
- Alignment: out = low WORD_WIDTH bits of ({left, right} >> s), computed on 2*WORD_WIDTH bits.
  - s=0 gives right exactly.
  - A word whose flag is invalid is treated as 0, regardless of the bus value.
- pos_ready = (state==IDLE) && sr_ready.
- FSM states:
  - IDLE: on pos_valid && pos_ready, register indices, flags, s and dummy, then go to REQ.
  - REQ: get_pair=1, with indices and flags held stable. At the edge where pair_valid=1, capture the four words, drop get_pair next cycle, go to ALIGN. REQ waits indefinitely.
  - ALIGN: one cycle. Register out_high, out_low, out_dummy; set out_valid; go to OUT.
  - OUT: hold out_* stable while out_valid && !out_ready. On out_ready, clear out_valid and go to IDLE.
- Latency: pos accept edge N → get_pair high in cycle N+1. If pair_valid is sampled at edge N+1+k, out_valid is high from N+3+k. Minimum accept-to-out_valid is 3 cycles.
- Throughput: one position per 4 cycles minimum; no overlap between transactions.
- Dummy: pos_dummy affects only out_dummy. Cycle count, requests and datapath are identical to a real position.
- abort: highest priority in every state. The next state is IDLE, get_pair and out_valid go low, and any in-flight result is dropped without being presented.
- Reset mid-transaction: immediate IDLE. No partial output is presented afterwards.
- Out-of-range position (w >= sr_size): all flags 0, outputs 0, normal handshake.
- Simultaneous abort and pos_valid in IDLE: abort wins and the position is not accepted.

Decomposition:
- Shared package: WORD_WIDTH, MAX_SIZE, IDX_W, POS_W defaults; FSM state encoding (IDLE, REQ, ALIGN, OUT).
- One sub-module: pair_funnel_shifter. It is combinational: inputs {left, right, left_v, right_v, s}, output the aligned word. It is instantiated twice (high and low).

Test Plan:
- Load words F0F0F0F0, 0F0F0F0F, AAAAAAAA, 55555555, 12345678, 87654321, … (19 words); pos=72 → out_low=55AAAAAA, out_high=78555555, out_dummy=0; out_valid 3 cycles after accept, given pair_valid in the first REQ cycle.
- pos=128 (s=0) → out_low=12345678, out_high=87654321.
- sr_size=19, pos=580 (w=18, word18=CAFEBABE) → low_left_valid=0, high flags 0; out_low=0CAFEBAB, out_high=00000000.
- pos=72 with pos_dummy=1 → same words as scenario 1, out_dummy=1, identical cycle count.
- out_ready held low 5 cycles → out_high/out_low/out_valid stable, pos_ready=0; release → out_valid drops next edge, pos_ready returns.
- abort asserted in REQ, and separately rst_n pulsed in ALIGN → IDLE next cycle, get_pair=0, no out_valid; a following pos=72 completes correctly.
